// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access unit: FSM states, RV32I
// load/store Funct3 encodings and access-size helpers.
package mem_access_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        ACC1,
        WAIT,
        DONE
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SIZE_B;
            2'b01:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        return f3 inside {F3_SB, F3_SH, F3_SW};
    endfunction

    function automatic logic crosses_word(input logic [1:0] off, input logic [2:0] size);
        return ({2'b00, off} + {1'b0, size}) > 4'd4;
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Byte selection from a two-word window and sign/zero extension of load data.
module load_extend
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word0,
    input  logic [DATA_W-1:0] word1,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] sel;

    always_comb begin
        sel = DATA_W'({word1, word0} >> {off, 3'b000});
        case (funct3)
            F3_LB:   data = {{(DATA_W-8){sel[7]}}, sel[7:0]};
            F3_LBU:  data = {{(DATA_W-8){1'b0}}, sel[7:0]};
            F3_LH:   data = {{(DATA_W-16){sel[15]}}, sel[15:0]};
            F3_LHU:  data = {{(DATA_W-16){1'b0}}, sel[15:0]};
            default: data = sel;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: splits misaligned accesses across two word
// cycles, aligns store lanes and assembles load data.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wd,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_W-1:0]     rd,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic                  mem_re,
    output logic [3:0]            mem_wr,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_t state, next_state;

    logic [1:0]        a_off;
    logic [2:0]        a_f3;
    logic              a_load;
    logic              a_legal;
    logic              a_split;
    logic [3:0]        a_wr_hi;
    logic [DATA_W-1:0] word0;
    logic [DATA_W-1:0] lo_word;
    logic [DATA_W-1:0] ld_data;

    logic              accept;
    logic              in_legal;
    logic              in_split;
    logic [2:0]        in_size;
    logic [7:0]        in_mask;
    logic [DATA_W-1:0] in_rot;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready && (MemRead || MemWrite);
    assign in_legal  = f3_legal(MemRead, Funct3);
    assign in_size   = access_size(Funct3);
    assign in_split  = in_legal && crosses_word(addr[1:0], in_size);
    assign in_mask   = {4'b0000, size_mask(in_size)} << addr[1:0];
    assign in_rot    = DATA_W'(({wd, wd} << {addr[1:0], 3'b000}) >> DATA_W);

    // Unsplit loads read their only word straight off mem_rdata in WAIT.
    assign lo_word = a_split ? word0 : mem_rdata;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .word0  (lo_word),
        .word1  (mem_rdata),
        .off    (a_off),
        .funct3 (a_f3),
        .data   (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = ACC0;
            ACC0: begin
                if (!a_legal)     next_state = DONE;
                else if (a_split) next_state = ACC1;
                else if (a_load)  next_state = WAIT;
                else              next_state = DONE;
            end
            ACC1:    next_state = a_load ? WAIT : DONE;
            WAIT:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory-side outputs are registered on the edge entering ACC0/ACC1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd         <= '0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_wr     <= '0;
            mem_wd     <= '0;
            a_off      <= '0;
            a_f3       <= '0;
            a_load     <= 1'b0;
            a_legal    <= 1'b0;
            a_split    <= 1'b0;
            a_wr_hi    <= '0;
            word0      <= '0;
        end else begin
            resp_valid <= 1'b0;
            mem_re     <= 1'b0;
            mem_wr     <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_off   <= addr[1:0];
                        a_f3    <= Funct3;
                        a_load  <= MemRead;
                        a_legal <= in_legal;
                        a_split <= in_split;
                        a_wr_hi <= in_mask[7:4];
                        if (in_legal) begin
                            mem_addr <= {addr[DM_ADDRESS-1:2], 2'b00};
                            mem_re   <= MemRead;
                            if (!MemRead) begin
                                mem_wr <= in_mask[3:0];
                                mem_wd <= in_rot;
                            end
                        end
                    end
                end
                ACC0: begin
                    if (next_state == ACC1) begin
                        mem_addr <= mem_addr + DM_ADDRESS'(4);
                        mem_re   <= a_load;
                        mem_wr   <= a_load ? 4'b0000 : a_wr_hi;
                    end
                end
                ACC1:    word0 <= mem_rdata;
                default: ;
            endcase
            if (next_state == DONE) begin
                resp_valid <= 1'b1;
                resp_err   <= !a_legal;
                rd         <= (a_legal && a_load) ? ld_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-addressed reference memory,
// directed corner cases, randomized traffic and asynchronous reset.
module tb_mem_access_unit;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          req_valid = 1'b0;
    logic          MemRead   = 1'b0;
    logic          MemWrite  = 1'b0;
    logic [2:0]    Funct3    = '0;
    logic [AW-1:0] addr      = '0;
    logic [DW-1:0] wd        = '0;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_err;
    logic [DW-1:0] rd;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [3:0]    mem_wr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rdata = '0;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [0:127];
    bit          mem_ready = 1'b0;
    logic [7:0]  ref_mem [0:511];

    always #5 clk = ~clk;

    mem_access_unit #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .addr       (addr),
        .wd         (wd),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .rd         (rd),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_wr     (mem_wr),
        .mem_wd     (mem_wd),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] hash(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // Word memory driven by the DUT's strobes; read data one cycle after mem_re.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] <= hash(i);
            mem_ready <= 1'b1;
        end else begin
            if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wr[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        end
    end

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal_of(input bit ld, input logic [2:0] f3);
        if (ld) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return f3 <= 3'd2;
    endfunction

    function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int n;
        v = '0;
        n = size_of(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % 512];
        if (f3 == 3'd0)      v = {{24{v[7]}}, v[7:0]};
        else if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic run_req(input bit r, input bit w, input logic [2:0] f3, input logic [8:0] a,
                           input logic [31:0] d, output logic [31:0] rd_obs, output int lat_obs);
        bit          ld, legal, split, seen, exp_re;
        int          sz, off, lat_exp, ba;
        logic [7:0]  mask8;
        logic [3:0]  exp_wr;
        logic [8:0]  wa0, wa1, exp_addr;
        logic [31:0] exp_rd, wtmp;
        ld      = r;
        legal   = legal_of(ld, f3);
        sz      = size_of(f3);
        off     = int'(a[1:0]);
        split   = legal && (off + sz > 4);
        lat_exp = !legal ? 2 : (ld ? (split ? 4 : 3) : (split ? 3 : 2));
        mask8   = '0;
        if (legal && !ld)
            for (int i = 0; i < sz; i++) mask8[off + i] = 1'b1;
        wa0    = {a[8:2], 2'b00};
        wa1    = wa0 + 9'd4;
        exp_rd = (legal && ld) ? ref_load(a, f3) : 32'h0;

        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; MemRead = r; MemWrite = w; Funct3 = f3; addr = a; wd = d;
        @(posedge clk); #1;
        // Garbage on every input while busy: none of it may be taken.
        req_valid = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
        Funct3 = 3'($urandom); addr = 9'($urandom); wd = $urandom;

        seen = 1'b0; lat_obs = 0; rd_obs = 'x;
        for (int k = 1; k <= 6 && !seen; k++) begin
            exp_wr = 4'b0000;
            if (legal && !ld) begin
                if (k == 1)               exp_wr = mask8[3:0];
                else if (k == 2 && split) exp_wr = mask8[7:4];
            end
            exp_re = legal && ld && (k == 1 || (k == 2 && split));
            vectors++;
            if (mem_wr !== exp_wr) begin
                miscompares++;
                $display("FAIL mem_wr f3=%0d a=%h cyc=%0d: got %b required %b", f3, a, k, mem_wr, exp_wr);
            end
            vectors++;
            if (mem_re !== exp_re) begin
                miscompares++;
                $display("FAIL mem_re f3=%0d a=%h cyc=%0d: got %b required %b", f3, a, k, mem_re, exp_re);
            end
            if (exp_wr != 4'b0000 || exp_re) begin
                exp_addr = (k == 1) ? wa0 : wa1;
                vectors++;
                if (mem_addr !== exp_addr) begin
                    miscompares++;
                    $display("FAIL mem_addr a=%h cyc=%0d: got %h required %h", a, k, mem_addr, exp_addr);
                end
            end
            if (resp_valid === 1'b1) begin
                seen = 1'b1; lat_obs = k; rd_obs = rd;
                req_valid = 1'b0;
                vectors++;
                if (k != lat_exp) begin
                    miscompares++;
                    $display("FAIL latency f3=%0d a=%h ld=%0d: got %0d required %0d", f3, a, ld, k, lat_exp);
                end
                vectors++;
                if (resp_err !== !legal) begin
                    miscompares++;
                    $display("FAIL resp_err f3=%0d ld=%0d: got %b required %b", f3, ld, resp_err, !legal);
                end
                if (ld || !legal) begin
                    vectors++;
                    if (rd !== exp_rd) begin
                        miscompares++;
                        $display("FAIL rd f3=%0d a=%h: got %h required %h", f3, a, rd, exp_rd);
                    end
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL resp_timeout f3=%0d a=%h: got no resp_valid in 6 cycles, required at %0d", f3, a, lat_exp);
        end else begin
            @(posedge clk); #1;
            vectors++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL resp_pulse: got resp_valid=%b req_ready=%b required 0/1", resp_valid, req_ready);
            end
        end

        if (legal && !ld) begin
            for (int i = 0; i < sz; i++) begin
                ba = (int'(a) + i) % 512;
                ref_mem[ba] = d[8*i +: 8];
                wtmp = mem[ba / 4];
                vectors++;
                if (wtmp[8*(ba % 4) +: 8] !== ref_mem[ba]) begin
                    miscompares++;
                    $display("FAIL store_byte @%h: got %h required %h", ba[8:0], wtmp[8*(ba % 4) +: 8], ref_mem[ba]);
                end
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || mem_re !== 1'b0 || mem_wr !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got rv=%b re=%b mre=%b mwr=%b required all 0", resp_valid, resp_err, mem_re, mem_wr);
        end
        vectors++;
        if (rd !== '0 || mem_addr !== '0 || mem_wd !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got rd=%h maddr=%h mwd=%h required 0", rd, mem_addr, mem_wd);
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic check_const(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic test_directed();
        logic [31:0] r;
        int          l;
        run_req(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, r, l); check_const("sw_lat", 32'(l), 32'd2);
        check_const("sw_word", mem[4], 32'hDEADBEEF);
        run_req(0, 1, 3'b010, 9'h010, 32'h80FF7F01, r, l);
        run_req(1, 0, 3'b000, 9'h012, 32'h0, r, l); check_const("lb_rd", r, 32'hFFFFFFFF);
        check_const("lb_lat", 32'(l), 32'd3);
        run_req(1, 0, 3'b100, 9'h012, 32'h0, r, l); check_const("lbu_rd", r, 32'h000000FF);
        run_req(1, 0, 3'b001, 9'h012, 32'h0, r, l); check_const("lh_rd", r, 32'hFFFF80FF);
        run_req(0, 1, 3'b001, 9'h013, 32'h0000ABCD, r, l); check_const("sh_split_lat", 32'(l), 32'd3);
        run_req(0, 1, 3'b010, 9'h1FC, 32'hAABBCCDD, r, l);
        run_req(0, 1, 3'b010, 9'h000, 32'h11223344, r, l);
        run_req(1, 0, 3'b010, 9'h1FE, 32'h0, r, l); check_const("lw_wrap_rd", r, 32'h3344AABB);
        check_const("lw_wrap_lat", 32'(l), 32'd4);
        run_req(0, 1, 3'b011, 9'h020, 32'h12345678, r, l); check_const("illegal_rd", r, 32'h0);
        check_const("illegal_lat", 32'(l), 32'd2);
        run_req(1, 1, 3'b010, 9'h010, 32'h55555555, r, l); check_const("rw_prio_rd", r, 32'hCDFF7F01);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int          l;
        bit          rr;
        for (int n = 0; n < 40; n++) begin
            rr = 1'($urandom);
            run_req(rr, rr ? 1'($urandom) : 1'b1, 3'($urandom), 9'($urandom), $urandom, r, l);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        int          l;
        bit          rr;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            rr = 1'($urandom);
            run_req(rr, rr ? 1'($urandom) : 1'b1, 3'($urandom), 9'($urandom), $urandom, r, l);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] r;
        int          l;
        bit          bad;
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b001; addr = 9'h013; wd = 32'h0000ABCD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_const("mid_acc0_wr", 32'(mem_wr), 32'b1000);
        @(posedge clk); #1;
        check_const("mid_acc1_wr", 32'(mem_wr), 32'b0001);
        #2 reset = 1'b0;
        #1;
        check_const("mid_rst_wr", 32'(mem_wr), 32'h0);
        check_const("mid_rst_addr", 32'(mem_addr), 32'h0);
        check_const("mid_rst_ready", 32'(req_ready), 32'h1);
        ref_mem[9'h013] = 8'hCD;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0 || mem_wr !== 4'b0) bad = 1'b1;
        end
        reset = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL mid_rst_quiet: got activity during reset, required none");
        end
        run_req(1, 0, 3'b010, 9'h012, 32'h0, r, l);
        run_req(1, 0, 3'b001, 9'h013, 32'h0, r, l);
    endtask

    initial begin
        logic [31:0] tmp;
        for (int wi = 0; wi < 128; wi++) begin
            tmp = hash(wi);
            for (int b = 0; b < 4; b++) ref_mem[4*wi + b] = tmp[8*b +: 8];
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameters: DM_ADDRESS, default 9, memory byte-address width; DATA_W, default 32, data width.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline MEM-stage request.
- req_ready  out  1  unit idle and accepting.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- Funct3  in  3  access size/sign, RV32I encoding.
- addr  in  DM_ADDRESS  byte address.
- wd  in  DATA_W  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  illegal Funct3, qualified by resp_valid.
- rd  out  DATA_W  extended load data, qualified by resp_valid.
- mem_addr  out  DM_ADDRESS  word-aligned address, bits [1:0]=0.
- mem_re  out  1  word read enable.
- mem_wr  out  4  per-byte write strobes.
- mem_wd  out  DATA_W  lane-aligned write data.
- mem_rdata  in  DATA_W  read word, valid one cycle after mem_re.

Function
REQ-003 SHALL accept a request when req_valid && req_ready && (MemRead || MemWrite); SHALL latch addr, wd, Funct3, type; SHALL ignore inputs while busy.
REQ-004 MemRead SHALL take priority when MemRead and MemWrite are both high.
REQ-005 Legal Funct3 values SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other value SHALL cause no memory access, and two cycles after acceptance SHALL give resp_valid=1, resp_err=1, rd=0.
REQ-006 FSM states SHALL be IDLE, ACC0, ACC1, WAIT, DONE; req_ready=1 only in IDLE.
REQ-007 IDLE->ACC0 on accept; ACC0 SHALL drive the first word, at addr with [1:0] cleared.
REQ-008 An access SHALL be split when off+size>4, with off=addr[1:0] and size 1/2/4 bytes. Split: ACC0->ACC1, ACC1 drives the next word, mem_addr+4, wrapping mod 2^DM_ADDRESS.
REQ-009 Unsplit: store ACC0->DONE, load ACC0->WAIT. Split: store ACC1->DONE, load ACC1->WAIT.
REQ-010 Loads: mem_re=1 in ACC0/ACC1. mem_rdata SHALL be captured in the cycle after each mem_re. WAIT captures the last word, then ->DONE.
REQ-011 Load assembly: bytes [off..off+size-1] of the concatenation {word1,word0} SHALL be right-justified. LB/LH sign-extend; LBU/LHU/LW zero-fill.
REQ-012 Stores: mem_wd SHALL be wd rotated left by 8*off. mem_wr SHALL be the size mask shifted left by off: low 4 bits in ACC0, carry-out bits in ACC1.
REQ-013 DONE: resp_valid=1 for exactly one cycle with registered rd/resp_err, then ->IDLE; a new request SHALL be acceptable the next cycle.
REQ-014 Latency from accept edge T:
- aligned store: resp at T+2
- split store: resp at T+3
- aligned load: resp at T+3
- split load: resp at T+4
REQ-015 Outside ACC0/ACC1: mem_wr=0, mem_re=0, mem_addr and mem_wd hold. No strobe SHALL ever be asserted for an illegal or load access.

Reset
REQ-016 reset low SHALL immediately force IDLE and set resp_valid=0, resp_err=0, rd=0, mem_re=0, mem_wr=0, mem_addr=0, mem_wd=0, independent of clk.
REQ-017 Reset mid-access SHALL abandon the access with no further strobes. The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-018 A shared package mem_access_pkg SHALL hold the FSM state enum, the Funct3 load/store encodings, and the size constants.
REQ-019 One sub-module, load_extend, SHALL hold the combinational byte-select and sign/zero extension; mem_access_unit holds FSM, latches and store alignment.
REQ-020 The block SHALL be synthesizable, with no latches or multiple drivers.

Verification
REQ-021 SW addr=0x010, wd=0xDEADBEEF -> at T+1 mem_addr=0x010, mem_wr=1111, mem_wd=0xDEADBEEF; resp_valid at T+2, resp_err=0.
REQ-022 SH addr=0x013, wd=0x0000ABCD -> T+1 mem_addr=0x010, mem_wr=1000, mem_wd[31:24]=0xCD; T+2 mem_addr=0x014, mem_wr=0001, mem_wd[7:0]=0xAB; resp at T+3.
REQ-023 Memory word 0x010=0x80FF7F01, LB addr=0x012 -> rd=0xFFFFFFFF; LBU -> 0x000000FF; LH addr=0x012 -> 0xFFFF80FF; resp at T+3.
REQ-024 LW addr=0x1FE, word 0x1FC=0xAABBCCDD, word 0x000=0x11223344 -> second access mem_addr=0x000, rd=0x3344AABB, resp at T+4.
REQ-025 Funct3=011 with MemWrite -> no mem_wr, resp_valid with resp_err=1, rd=0 at T+2; MemRead and MemWrite both high with LW -> load performed, mem_wr stays 0.
REQ-026 reset pulsed low during ACC1 of a split SH -> mem_wr=0 immediately, resp_valid never pulses, req_ready=1 after release.
